// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// State encoding is fixed at 3 bits; cnt_width() sizes the shared phase counter.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } pll_state_e;

  // Width needed to hold the largest phase length (inclusive).
  function automatic int cnt_width(input int rst_cycles, input int timeout,
                                   input int filter, input int hold);
    int m;
    m = rst_cycles;
    if (timeout > m) m = timeout;
    if (filter > m)  m = filter;
    if (hold > m)    m = hold;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic single-bit two-flop synchroniser, asynchronously cleared to 0.
module sync_2ff (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic stage1_q, stage1_d;
  logic stage2_q, stage2_d;

  // Next values: shift the asynchronous input through both stages.
  always_comb begin
    stage1_d = d;
    stage2_d = stage1_q;
  end

  // Synchroniser flops, cleared to 0 while reset_n is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage1_q <= 1'b0;
      stage2_q <= 1'b0;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign q = stage2_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses PLL RESETB, waits for lock with timeout/retry,
// filters lock, then releases a stretched design reset.
// Optional macro PLL_SEQ_BYPASS_FALLBACK_EN: on FAIL, bypass the PLL and release
// reset after PLL_RST_CYCLES so the design runs from the reference clock.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int LOCK_FILTER    = 256,
  parameter int RESET_HOLD     = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             pll_lock,
  output logic                             pll_resetb,
  output logic                             pll_bypass,
  output logic                             reset,
  output logic                             locked,
  output logic                             fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_FILTER, RESET_HOLD);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock_s high already counts as the
  // first filter cycle, so STABLE only needs LOCK_FILTER-1 more.
  localparam logic [CW-1:0] FILTER_LAST  = CW'((LOCK_FILTER >= 2) ? LOCK_FILTER - 2 : 0);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(RESET_HOLD - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);
  localparam pll_state_e    LOCK_NEXT    = (LOCK_FILTER <= 1) ? HOLD : STABLE;

  logic lock_s;

  pll_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [RW-1:0] retry_sat;
  logic          pll_resetb_q, pll_resetb_d;
  logic          reset_q, reset_d;
  logic          locked_q, locked_d;
  logic          fail_q, fail_d;

  sync_2ff u_lock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (pll_lock),
    .q       (lock_s)
  );

  // Saturating increment used for every failed attempt.
  assign retry_sat = (retry_q == RETRY_MAX) ? retry_q : retry_q + 1'b1;

  // Next-state, shared counter and next-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (lock_s) begin
          state_d = LOCK_NEXT;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_sat;
          state_d = (retry_sat == RETRY_MAX) ? FAIL : PLL_RST;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        // A dropout restarts both the filter and the lock timeout.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == FILTER_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          retry_d = retry_sat;
          state_d = (retry_sat == RETRY_MAX) ? FAIL : PLL_RST;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Lock loss after a good start is not a failed attempt.
        cnt_d = cnt_q;
        if (!lock_s) begin
          state_d = PLL_RST;
          cnt_d   = '0;
        end
      end
      FAIL: begin
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
        cnt_d = (cnt_q == RST_LAST) ? cnt_q : cnt_q + 1'b1;
`else
        cnt_d = cnt_q;
`endif
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase

    reset_d  = (state_d != RUN);
    locked_d = (state_d == RUN);
    fail_d   = (state_d == FAIL);
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
    pll_resetb_d = (state_d != PLL_RST);
    if (state_q == FAIL && cnt_q == RST_LAST) reset_d = 1'b0;
`else
    pll_resetb_d = (state_d != PLL_RST) && (state_d != FAIL);
`endif
  end

  // State, counters and registered outputs; async clear to the reset values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_resetb_q <= 1'b0;
      reset_q      <= 1'b1;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_resetb_q <= pll_resetb_d;
      reset_q      <= reset_d;
      locked_q     <= locked_d;
      fail_q       <= fail_d;
    end
  end

`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
  logic pll_bypass_q, pll_bypass_d;

  // Bypass the PLL once the sequencer has given up on it.
  always_comb pll_bypass_d = (state_d == FAIL);

  // Registered bypass select.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pll_bypass_q <= 1'b0;
    else          pll_bypass_q <= pll_bypass_d;
  end

  assign pll_bypass = pll_bypass_q;
`else
  assign pll_bypass = 1'b0;
`endif

  assign pll_resetb  = pll_resetb_q;
  assign reset       = reset_q;
  assign locked      = locked_q;
  assign fail        = fail_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer (PLL_RST_CYCLES=4, LOCK_TIMEOUT=32,
// LOCK_FILTER=8, RESET_HOLD=16, MAX_RETRIES=3). Honours PLL_SEQ_BYPASS_FALLBACK_EN.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
module tb_pll_reset_sequencer;

  logic       clock;
  logic       reset_n;
  logic       pll_lock;
  logic       pll_resetb;
  logic       pll_bypass;
  logic       reset;
  logic       locked;
  logic       fail;
  logic [1:0] retry_count;

  int n_cmp = 0;
  int n_bad = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (32),
    .LOCK_FILTER    (8),
    .RESET_HOLD     (16),
    .MAX_RETRIES    (3)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pll_lock    (pll_lock),
    .pll_resetb  (pll_resetb),
    .pll_bypass  (pll_bypass),
    .reset       (reset),
    .locked      (locked),
    .fail        (fail),
    .retry_count (retry_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-24s observed %0d expected %0d", tag, obs, exp);
  endtask

  // Assert reset_n between edges, release it one edge later (next edge is edge 1).
  task automatic do_reset();
    reset_n  = 1'b0;
    pll_lock = 1'b0;
    cyc(1);
    reset_n  = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    pll_lock = 1'b0;
    cyc(2);
    check("rst pll_resetb", 32'(pll_resetb), 32'd0);
    check("rst pll_bypass", 32'(pll_bypass), 32'd0);
    check("rst reset", 32'(reset), 32'd1);
    check("rst locked", 32'(locked), 32'd0);
    check("rst fail", 32'(fail), 32'd0);
    check("rst retry", 32'(retry_count), 32'd0);

    // ---- Nominal lock ----
    reset_n = 1'b1;
    cyc(3);
    check("nom resetb e3", 32'(pll_resetb), 32'd0);
    cyc(1);
    check("nom resetb e4", 32'(pll_resetb), 32'd1);
    cyc(10);
    pll_lock = 1'b1;                 // 2 sync + 8 filter + 16 hold = 26 edges
    cyc(25);
    check("nom reset p25", 32'(reset), 32'd1);
    check("nom locked p25", 32'(locked), 32'd0);
    cyc(1);
    check("nom reset p26", 32'(reset), 32'd0);
    check("nom locked p26", 32'(locked), 32'd1);
    check("nom retry", 32'(retry_count), 32'd0);
    check("nom fail", 32'(fail), 32'd0);

    // ---- Lock loss in RUN ----
    pll_lock = 1'b0;
    cyc(1);
    pll_lock = 1'b1;
    check("loss reset r1", 32'(reset), 32'd0);
    cyc(1);
    check("loss reset r2", 32'(reset), 32'd0);
    cyc(1);
    check("loss reset r3", 32'(reset), 32'd1);
    check("loss locked r3", 32'(locked), 32'd0);
    check("loss resetb r3", 32'(pll_resetb), 32'd0);
    cyc(3);
    check("loss resetb r6", 32'(pll_resetb), 32'd0);
    cyc(1);
    check("loss resetb r7", 32'(pll_resetb), 32'd1);
    cyc(23);
    check("loss reset r30", 32'(reset), 32'd1);
    cyc(1);
    check("loss reset r31", 32'(reset), 32'd0);
    check("loss locked r31", 32'(locked), 32'd1);
    check("loss retry", 32'(retry_count), 32'd0);

    // ---- Filter glitch ----
    do_reset();
    cyc(4);
    check("glt resetb e4", 32'(pll_resetb), 32'd1);
    pll_lock = 1'b1;
    cyc(5);
    pll_lock = 1'b0;
    cyc(1);
    pll_lock = 1'b1;                 // re-rise: release 2 + 24 edges later
    cyc(19);
    check("glt reset unglitched", 32'(reset), 32'd1);
    cyc(6);
    check("glt reset q25", 32'(reset), 32'd1);
    cyc(1);
    check("glt reset q26", 32'(reset), 32'd0);
    check("glt locked", 32'(locked), 32'd1);
    check("glt retry", 32'(retry_count), 32'd0);

    // ---- Timeout / retry ----
    do_reset();
    cyc(4);
    check("to resetb e4", 32'(pll_resetb), 32'd1);
    cyc(31);
    check("to retry e35", 32'(retry_count), 32'd0);
    check("to resetb e35", 32'(pll_resetb), 32'd1);
    cyc(1);
    check("to retry e36", 32'(retry_count), 32'd1);
    check("to resetb e36", 32'(pll_resetb), 32'd0);
    cyc(3);
    check("to resetb e39", 32'(pll_resetb), 32'd0);
    cyc(1);
    check("to resetb e40", 32'(pll_resetb), 32'd1);
    cyc(32);
    check("to retry e72", 32'(retry_count), 32'd2);
    check("to resetb e72", 32'(pll_resetb), 32'd0);
    cyc(4);
    check("to resetb e76", 32'(pll_resetb), 32'd1);
    cyc(31);
    check("to fail e107", 32'(fail), 32'd0);
    check("to retry e107", 32'(retry_count), 32'd2);
    cyc(1);
    check("to fail e108", 32'(fail), 32'd1);
    check("to retry e108", 32'(retry_count), 32'd3);
    check("to reset e108", 32'(reset), 32'd1);
    check("to locked e108", 32'(locked), 32'd0);
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
    check("fb resetb e108", 32'(pll_resetb), 32'd1);
    check("fb bypass e108", 32'(pll_bypass), 32'd1);
    cyc(3);
    check("fb reset e111", 32'(reset), 32'd1);
    cyc(1);
    check("fb reset e112", 32'(reset), 32'd0);
    check("fb locked e112", 32'(locked), 32'd0);
    check("fb fail e112", 32'(fail), 32'd1);
    cyc(40);
    check("fb reset late", 32'(reset), 32'd0);
`else
    check("to resetb e108", 32'(pll_resetb), 32'd0);
    check("to bypass e108", 32'(pll_bypass), 32'd0);
    cyc(44);
    check("to reset late", 32'(reset), 32'd1);
    check("to resetb late", 32'(pll_resetb), 32'd0);
`endif
    check("to fail late", 32'(fail), 32'd1);
    check("to retry late", 32'(retry_count), 32'd3);

    // ---- Async reset mid-HOLD (after one failed attempt) ----
    do_reset();
    cyc(36);
    check("ar retry e36", 32'(retry_count), 32'd1);
    cyc(4);
    check("ar resetb e40", 32'(pll_resetb), 32'd1);
    pll_lock = 1'b1;
    cyc(15);                          // inside HOLD
    check("ar hold resetb", 32'(pll_resetb), 32'd1);
    check("ar hold reset", 32'(reset), 32'd1);
    check("ar hold retry", 32'(retry_count), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;                               // still between edges
    check("ar resetb", 32'(pll_resetb), 32'd0);
    check("ar reset", 32'(reset), 32'd1);
    check("ar locked", 32'(locked), 32'd0);
    check("ar fail", 32'(fail), 32'd0);
    check("ar retry", 32'(retry_count), 32'd0);
    check("ar bypass", 32'(pll_bypass), 32'd0);
    cyc(3);
    check("ar held resetb", 32'(pll_resetb), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
